// File: rtl/controle_memoria_dados.sv
// controle_memoria_dados
// Load/store unit between the datapath and the external data SRAM. It turns
// one load or store request into a word-wide SRAM transaction with byte
// enables, waits for the acknowledge (bounded by TIMEOUT cycles) and returns
// the load result aligned and sign/zero-extended.
//
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   req                 : request strobe, sampled only while idle
//   escrita             : 1 = store, 0 = load
//   tamanho             : 00 byte, 01 half, 1x word
//   com_sinal           : load extension, 1 = sign, 0 = zero
//   endereco            : byte address
//   dado_escrita        : right-justified store data
//   saida_memoria       : registered load result
//   pronto              : one-cycle completion pulse
//   ocupado             : high while a transaction is in flight
//   erro                : 00 ok, 01 misaligned, 10 timeout (valid with pronto)
//   mem_req/mem_we      : SRAM request / write enable
//   mem_addr            : SRAM word address
//   mem_be              : byte enables, bit i = lane i
//   mem_wdata           : lane-replicated store data
//   mem_rdata, mem_ack  : SRAM read word and completion
module controle_memoria_dados #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        escrita,
  input  logic [1:0]  tamanho,
  input  logic        com_sinal,
  input  logic [31:0] endereco,
  input  logic [31:0] dado_escrita,
  output logic [31:0] saida_memoria,
  output logic        pronto,
  output logic        ocupado,
  output logic [1:0]  erro,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {OCIOSO, ESPERA, CONCLUI} estado_t;

  // Last counter value before the abort; counter starts at 0 on entry.
  localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

  estado_t     r_estado;
  logic [7:0]  r_cont;
  logic [31:0] r_saida;
  logic [1:0]  r_erro;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_escrita;
  logic [1:0]  r_tam;
  logic        r_sinal;
  logic [1:0]  r_lsb;
  logic [31:0] w_dado_lido;

  function automatic logic f_desalinhado(input logic [1:0] tam, input logic [1:0] a);
    logic res;
    res = 1'b0;
    if (tam == 2'b01)  res = a[0];
    else if (tam[1])   res = (a != 2'b00);
    return res;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] tam, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    if (tam == 2'b00)      be = 4'b0001 << a;
    else if (tam == 2'b01) be = a[1] ? 4'b1100 : 4'b0011;
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] tam, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    if (tam == 2'b00)      w = {4{d[7:0]}};
    else if (tam == 2'b01) w = {2{d[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] f_extrai(input logic [1:0] tam, input logic [1:0] a,
                                           input logic sinal, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (tam)
      2'b00:   res = {{24{sinal & b[7]}}, b};
      2'b01:   res = {{16{sinal & h[15]}}, h};
      default: res = w;
    endcase
    return res;
  endfunction

  assign w_dado_lido = f_extrai(r_tam, r_lsb, r_sinal, mem_rdata);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_cont    <= '0;
      r_saida   <= '0;
      r_erro    <= 2'b00;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_escrita <= 1'b0;
      r_tam     <= 2'b00;
      r_sinal   <= 1'b0;
      r_lsb     <= 2'b00;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (req) begin
            r_escrita <= escrita;
            r_tam     <= tamanho;
            r_sinal   <= com_sinal;
            r_lsb     <= endereco[1:0];
            r_addr    <= endereco[31:2];
            r_be      <= f_be(tamanho, endereco[1:0]);
            r_wdata   <= f_wdata(tamanho, dado_escrita);
            r_cont    <= '0;
            if (f_desalinhado(tamanho, endereco[1:0])) begin
              r_erro   <= 2'b01;
              r_estado <= CONCLUI;
            end else begin
              r_estado <= ESPERA;
            end
          end
        end
        ESPERA: begin
          // Ack is checked first so it wins over the timeout limit.
          if (mem_ack) begin
            if (!r_escrita) r_saida <= w_dado_lido;
            r_erro   <= 2'b00;
            r_estado <= CONCLUI;
          end else if (r_cont == LIMITE) begin
            r_erro   <= 2'b10;
            r_estado <= CONCLUI;
          end else begin
            r_cont <= r_cont + 8'd1;
          end
        end
        CONCLUI: r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  // Status outputs are decoded straight from the state register.
  assign pronto        = (r_estado == CONCLUI);
  assign ocupado       = (r_estado != OCIOSO);
  assign mem_req       = (r_estado == ESPERA);
  assign mem_we        = (r_estado == ESPERA) & r_escrita;
  assign saida_memoria = r_saida;
  assign erro          = r_erro;
  assign mem_addr      = r_addr;
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;

endmodule

// File: tb/tb_controle_memoria_dados.sv
module tb_controle_memoria_dados;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        escrita;
  logic [1:0]  tamanho;
  logic        com_sinal;
  logic [31:0] endereco;
  logic [31:0] dado_escrita;
  logic [31:0] saida_memoria;
  logic        pronto;
  logic        ocupado;
  logic [1:0]  erro;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  // Observations of the last transaction.
  int          t_cyc;
  int          t_nreq;
  logic        t_we;
  logic [29:0] t_addr;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;

  controle_memoria_dados #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req(req), .escrita(escrita),
    .tamanho(tamanho), .com_sinal(com_sinal), .endereco(endereco),
    .dado_escrita(dado_escrita), .saida_memoria(saida_memoria),
    .pronto(pronto), .ocupado(ocupado), .erro(erro), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_saida"},  saida_memoria, 32'h0);
    chk({tag, "_pronto"}, 32'(pronto), 32'h0);
    chk({tag, "_ocup"},   32'(ocupado), 32'h0);
    chk({tag, "_erro"},   32'(erro), 32'h0);
    chk({tag, "_mreq"},   32'(mem_req), 32'h0);
    chk({tag, "_mwe"},    32'(mem_we), 32'h0);
    chk({tag, "_maddr"},  32'(mem_addr), 32'h0);
    chk({tag, "_mbe"},    32'(mem_be), 32'h0);
    chk({tag, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  // Issues one request, acks after ack_after wait cycles (negative = never),
  // and stops at the negedge where pronto is seen. t_cyc is the cycle of
  // pronto counted from the request edge.
  task automatic run(input logic we, input logic [1:0] tam, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int ack_after);
    @(negedge clock);
    req = 1'b1; escrita = we; tamanho = tam; com_sinal = sg;
    endereco = addr; dado_escrita = wd;
    @(negedge clock);
    req = 1'b0;
    t_cyc = 1; t_nreq = 0;
    t_we = mem_we; t_addr = mem_addr; t_be = mem_be; t_wdata = mem_wdata;
    while (pronto !== 1'b1 && t_cyc < 100) begin
      if (mem_req === 1'b1) begin
        if (t_nreq == ack_after) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        t_nreq++;
      end
      @(negedge clock);
      mem_ack = 1'b0;
      t_cyc++;
    end
    if (t_cyc >= 100) chk("pronto_bound", 32'(t_cyc), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; escrita = 1'b0; tamanho = 2'b00; com_sinal = 1'b0;
    endereco = '0; dado_escrita = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;

    // Word load, two wait cycles.
    run(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 2);
    chk("wl_addr", 32'(t_addr), 32'h40);
    chk("wl_be", 32'(t_be), 32'hF);
    chk("wl_we", 32'(t_we), 32'h0);
    chk("wl_cyc", 32'(t_cyc), 32'd4);
    chk("wl_saida", saida_memoria, 32'hDEADBEEF);
    chk("wl_erro", 32'(erro), 32'h0);
    @(negedge clock);
    chk("wl_pulse", 32'(pronto), 32'h0);
    chk("wl_ocup", 32'(ocupado), 32'h0);

    // Byte load at lane 3, signed then unsigned.
    run(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h80123456, 0);
    chk("bs_be", 32'(t_be), 32'h8);
    chk("bs_addr", 32'(t_addr), 32'h800);
    chk("bs_cyc", 32'(t_cyc), 32'd2);
    chk("bs_saida", saida_memoria, 32'hFFFFFF80);
    run(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 32'h80123456, 0);
    chk("bu_be", 32'(t_be), 32'h8);
    chk("bu_saida", saida_memoria, 32'h00000080);

    // Half store at offset 2.
    run(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000ABCD, 32'h11111111, 1);
    chk("hs_we", 32'(t_we), 32'h1);
    chk("hs_be", 32'(t_be), 32'hC);
    chk("hs_wdata", t_wdata, 32'hABCDABCD);
    chk("hs_saida", saida_memoria, 32'h00000080);
    chk("hs_erro", 32'(erro), 32'h0);

    // Misaligned word load, then a request during the pronto cycle.
    run(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h22222222, -1);
    chk("mis_cyc", 32'(t_cyc), 32'd1);
    chk("mis_nreq", 32'(t_nreq), 32'd0);
    chk("mis_erro", 32'(erro), 32'h1);
    req = 1'b1; escrita = 1'b0; tamanho = 2'b10; endereco = 32'h0000_0200;
    @(negedge clock);
    req = 1'b0;
    chk("ign_ocup", 32'(ocupado), 32'h0);
    chk("ign_mreq", 32'(mem_req), 32'h0);
    chk("ign_erro", 32'(erro), 32'h1);
    chk("ign_saida", saida_memoria, 32'h00000080);

    // Timeout with no ack.
    run(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h33333333, -1);
    chk("to_nreq", 32'(t_nreq), 32'd4);
    chk("to_cyc", 32'(t_cyc), 32'd5);
    chk("to_erro", 32'(erro), 32'h2);
    chk("to_saida", saida_memoria, 32'h00000080);

    // Ack in the last cycle before the timeout: signed half at offset 2.
    run(1'b0, 2'b01, 1'b1, 32'h0000_0502, 32'h0, 32'h80011234, 3);
    chk("la_nreq", 32'(t_nreq), 32'd4);
    chk("la_cyc", 32'(t_cyc), 32'd5);
    chk("la_erro", 32'(erro), 32'h0);
    chk("la_saida", saida_memoria, 32'hFFFF8001);

    // Reset during ESPERA, then an ack one cycle later.
    @(negedge clock);
    req = 1'b1; escrita = 1'b0; tamanho = 2'b10; endereco = 32'h0000_0600;
    @(negedge clock);
    req = 1'b0;
    chk("rm_mreq", 32'(mem_req), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h44444444;
    chk_reset("rm");
    @(negedge clock);
    mem_ack = 1'b0;
    chk("rm_pronto", 32'(pronto), 32'h0);
    chk("rm_ocup", 32'(ocupado), 32'h0);
    chk("rm_saida", saida_memoria, 32'h0);

    // Normal load after reset: unsigned byte at lane 1.
    run(1'b0, 2'b00, 1'b0, 32'h0000_0701, 32'h0, 32'h0000AB00, 1);
    chk("pr_be", 32'(t_be), 32'h2);
    chk("pr_cyc", 32'(t_cyc), 32'd3);
    chk("pr_saida", saida_memoria, 32'h000000AB);
    chk("pr_erro", 32'(erro), 32'h0);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
